latch_queue: RTL and testbench



---
 rtl/latch_queue.sv | 105 ++++++++++
 tb/tb_latch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_queue.sv
// Edge-captured latch feeding a DEPTH-entry circular queue.
// Words are captured when le falls and drained in order by pop.
module latch_queue #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int HOLD_LAST = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             din,
   input  logic                         le,
   input  logic                         oe_n,
   input  logic                         pop,
   input  logic                         clr,
   output logic [WIDTH-1:0]             dout,
   output logic                         valid,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_din_q;
   logic [WIDTH-1:0] r_last;
   logic             r_le_q;
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic             w_cap;
   logic             w_empty;
   logic             w_pop_ok;
   logic             w_push_ok;
   logic [WIDTH-1:0] w_head;

   assign w_cap     = r_le_q & ~le;
   assign w_empty   = (r_count == '0);
   assign w_pop_ok  = pop & ~w_empty;
   // a pop in the same cycle frees the slot a full queue needs
   assign w_push_ok = w_cap & ((r_count != FULL_CNT) | w_pop_ok);
   assign w_head    = r_mem[r_rp];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_le_q     <= 1'b0;
         r_din_q    <= '0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_last     <= '0;
      end else begin
         r_le_q  <= le;
         r_din_q <= din;
         if (clr) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_last     <= '0;
         end else begin
            if (w_push_ok)
               r_wp <= r_wp + AW'(1);
            if (w_pop_ok) begin
               r_rp <= r_rp + AW'(1);
               if (HOLD_LAST != 0)
                  r_last <= w_head;
            end
            if (w_push_ok && !w_pop_ok)
               r_count <= r_count + CW'(1);
            else if (!w_push_ok && w_pop_ok)
               r_count <= r_count - CW'(1);
            if (w_cap && !w_push_ok)
               r_overflow <= 1'b1;
         end
      end
   end

   // storage needs no reset; contents are meaningless until written
   always_ff @(posedge clk) begin
      if (!clr && w_push_ok)
         r_mem[r_wp] <= r_din_q;
   end

   always_comb begin
      dout = '0;
      if (!oe_n) begin
         if (!w_empty)
            dout = w_head;
         else if (HOLD_LAST != 0)
            dout = r_last;
      end
   end

   assign valid    = ~oe_n & ~w_empty;
   assign full     = (r_count == FULL_CNT);
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_latch_queue.sv
// Directed bench for latch_queue with a scoreboard of expected words.
module tb_latch_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       le;
   logic       oe_n;
   logic       pop;
   logic       clr;
   logic [7:0] dout;
   logic       valid;
   logic       full;
   logic [2:0] count;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] sb [$];

   latch_queue #(.WIDTH(8), .DEPTH(4), .HOLD_LAST(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .din      (din),
      .le       (le),
      .oe_n     (oe_n),
      .pop      (pop),
      .clr      (clr),
      .dout     (dout),
      .valid    (valid),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_chk(input string tag);
      logic [7:0] e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: observed %0h expected <scoreboard empty>",
                tag, dout);
      end else begin
         e = sb.pop_front();
         chk(tag, {56'd0, dout}, {56'd0, e});
      end
   endtask

   // le high for one cycle with w, then low with junk on din
   task automatic capture(input logic [7:0] w, input bit accept);
      din = w;
      le  = 1'b1;
      tick();
      le  = 1'b0;
      din = ~w;
      tick();
      if (accept) sb.push_back(w);
   endtask

   task automatic pop_chk(input string tag);
      sb_chk(tag);
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; din = 8'h5A; le = 1'b1;
      oe_n = 1'b0; pop = 1'b0; clr = 1'b0;
      tick(); tick();
      chk("rst_count", count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);

      // le held high through reset release: no capture
      reset = 1'b0;
      tick(); tick(); tick();
      chk("le_hi_count", count, 0);
      chk("le_hi_valid", valid, 0);
      chk("le_hi_dout", dout, 0);
      le = 1'b0;
      din = 8'h00;
      #1;
      chk("first_low_valid", valid, 0);
      tick();
      sb.push_back(8'h5A);
      chk("cap_valid", valid, 1);
      chk("cap_count", count, 1);
      pop_chk("first_word");
      chk("first_empty", valid, 0);

      // fill, then drain with hold-last
      capture(8'h11, 1);
      capture(8'h22, 1);
      capture(8'h33, 1);
      capture(8'h44, 1);
      chk("fill_full", full, 1);
      chk("fill_count", count, 4);
      pop_chk("drain0");
      pop_chk("drain1");
      pop_chk("drain2");
      pop_chk("drain3");
      chk("hold_last", dout, 8'h44);
      chk("hold_valid", valid, 0);
      chk("hold_count", count, 0);

      // overflow, then capture coincident with pop on a full queue
      capture(8'h11, 1);
      capture(8'h22, 1);
      capture(8'h33, 1);
      capture(8'h44, 1);
      capture(8'h55, 0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_count", count, 4);
      chk("ovf_head", dout, 8'h11);
      din = 8'h66;
      le  = 1'b1;
      tick();
      le  = 1'b0;
      din = 8'h00;
      sb_chk("popcap_head");
      pop = 1'b1;
      tick();
      pop = 1'b0;
      sb.push_back(8'h66);
      chk("popcap_count", count, 4);
      chk("popcap_ovf", overflow, 1);
      pop_chk("order0");
      pop_chk("order1");
      pop_chk("order2");
      pop_chk("order3");
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("pop_empty_count", count, 0);
      chk("pop_empty_dout", dout, 8'h66);

      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_ovf", overflow, 0);
      chk("clr_last", dout, 0);

      // capture with outputs disabled
      oe_n = 1'b1;
      capture(8'hA5, 1);
      chk("oe_dout", dout, 0);
      chk("oe_valid", valid, 0);
      chk("oe_count", count, 1);
      oe_n = 1'b0;
      #1;
      chk("oe_valid_on", valid, 1);
      pop_chk("oe_dout_on");

      // pop held high while streaming 8 words
      pop = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = 8'(8'h30 + i);
         le  = 1'b1;
         if (i > 0) begin
            chk("stream_count", count, 1);
            sb_chk("stream_word");
         end
         tick();
         le  = 1'b0;
         din = 8'hFF;
         chk("stream_drained", count, 0);
         tick();
         sb.push_back(8'(8'h30 + i));
      end
      chk("stream_last_count", count, 1);
      sb_chk("stream_last");
      tick();
      pop = 1'b0;
      chk("stream_end_count", count, 0);
      chk("stream_ovf", overflow, 0);
      chk("stream_hold", dout, 8'h37);

      // clr coincident with a capture edge loses that word
      capture(8'h77, 1);
      capture(8'h88, 1);
      capture(8'h99, 1);
      chk("pre_clr_count", count, 3);
      din = 8'hCC;
      le  = 1'b1;
      tick();
      le  = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      sb.delete();
      chk("clr_count", count, 0);
      chk("clr_ovf2", overflow, 0);
      chk("clr_dout", dout, 0);
      tick();
      chk("clr_lost_word", count, 0);

      // asynchronous reset mid-fill
      capture(8'hB1, 1);
      capture(8'hB2, 1);
      chk("mid_count", count, 2);
      reset = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_valid", valid, 0);
      chk("arst_dout", dout, 0);
      chk("arst_full", full, 0);
      sb.delete();
      tick();
      reset = 1'b0;
      capture(8'hC3, 1);
      pop_chk("post_rst_word");
      chk("post_rst_count", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
